// File: rtl/ft_tx_pkg.sv
//==============================================================================
// Module  : ft_tx_pkg
// Brief   : Shared FT transmit types and defaults (arbiter and channel FIFOs)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package ft_tx_pkg;

    // The channel FIFO wrappers use the same packet size as their prog_empty threshold
    localparam int c_default_packet_size   = 1024;
    localparam int c_default_settle_cycles = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_BURST  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ft_tx_arbiter_rr_picker.sv
//==============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin search starting after the last grant
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] last_grant,
    output logic                      found,
    output logic [$clog2(NUM_CH)-1:0] index
);

    localparam int c_gw = $clog2(NUM_CH);

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && req[(int'(last_grant) + i) % NUM_CH]) begin
                found = 1'b1;
                index = c_gw'((int'(last_grant) + i) % NUM_CH);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ft_tx_arbiter.sv
//==============================================================================
// Module  : ft_tx_arbiter
// Brief   : Packet-granular round-robin scheduler for the FT transmit bus
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module ft_tx_arbiter
    import ft_tx_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 32,
    parameter int PACKET_SIZE   = c_default_packet_size,
    parameter int SETTLE_CYCLES = c_default_settle_cycles
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_CH-1:0]         ch_ready_in,
    input  logic [NUM_CH-1:0]         ch_empty_in,
    input  logic [NUM_CH-1:0]         ch_valid_in,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data_in,
    input  logic                      txe_n_in,
    output logic [NUM_CH-1:0]         ch_rd_out,
    output logic [DATA_W-1:0]         data_out,
    output logic [DATA_W/8-1:0]       be_out,
    output logic                      wr_n_out,
    output logic [$clog2(NUM_CH)-1:0] grant_out,
    output logic                      busy_out,
    output logic                      underrun_out
);

    localparam int c_gw = $clog2(NUM_CH);
    localparam int c_sw = $clog2(SETTLE_CYCLES + 1);
    localparam int c_ww = $clog2(PACKET_SIZE + 1);

    localparam logic [c_sw-1:0]   c_settle_last = c_sw'(SETTLE_CYCLES - 1);
    localparam logic [c_ww-1:0]   c_word_last   = c_ww'(PACKET_SIZE - 1);
    localparam logic [c_gw-1:0]   c_last_ch     = c_gw'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] c_one         = NUM_CH'(1);

    state_t              r_state;
    logic [c_gw-1:0]     r_grant;
    logic [c_gw-1:0]     r_last_grant;
    logic [c_sw-1:0]     r_settle_ctr;
    logic [c_ww-1:0]     r_word_ctr;
    logic                r_drain_ctr;
    logic [NUM_CH-1:0]   r_ch_rd;
    logic [DATA_W-1:0]   r_data;
    logic                r_wr_n;
    logic                r_underrun;

    logic                w_found;
    logic [c_gw-1:0]     w_pick;

    rr_picker #(
        .NUM_CH     (NUM_CH)
    ) u_picker (
        .req        (ch_ready_in),
        .last_grant (r_last_grant),
        .found      (w_found),
        .index      (w_pick)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_last_ch;
            r_settle_ctr <= '0;
            r_word_ctr   <= '0;
            r_drain_ctr  <= 1'b0;
            r_ch_rd      <= '0;
            r_data       <= '0;
            r_wr_n       <= 1'b1;
            r_underrun   <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            // Bus register: valids keep flowing through DRAIN, dropped once IDLE
            r_data     <= ch_data_in[r_grant*DATA_W +: DATA_W];
            r_wr_n     <= !(ch_valid_in[r_grant] && (r_state != ST_IDLE));

            case (r_state)
                ST_IDLE: begin
                    r_ch_rd <= '0;
                    if (!txe_n_in && w_found) begin
                        r_grant      <= w_pick;
                        r_settle_ctr <= '0;
                        r_state      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (!txe_n_in && ch_ready_in[r_grant]) begin
                        if (r_settle_ctr == c_settle_last) begin
                            r_word_ctr <= '0;
                            r_ch_rd    <= c_one << r_grant;
                            r_state    <= ST_BURST;
                        end else begin
                            r_settle_ctr <= r_settle_ctr + c_sw'(1);
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                // txe_n is deliberately ignored here: a whole packet fits the FT buffer
                ST_BURST: begin
                    if (ch_empty_in[r_grant]) begin
                        r_underrun  <= 1'b1;
                        r_ch_rd     <= '0;
                        r_drain_ctr <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end else if (r_word_ctr == c_word_last) begin
                        r_ch_rd     <= '0;
                        r_drain_ctr <= 1'b0;
                        r_state     <= ST_DRAIN;
                    end else begin
                        r_word_ctr <= r_word_ctr + c_ww'(1);
                    end
                end

                ST_DRAIN: begin
                    r_ch_rd <= '0;
                    if (r_drain_ctr) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_drain_ctr <= 1'b1;
                    end
                end

                default: begin
                    r_ch_rd <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ch_rd_out    = r_ch_rd;
    assign data_out     = r_data;
    assign be_out       = '1;
    assign wr_n_out     = r_wr_n;
    assign grant_out    = r_grant;
    assign busy_out     = (r_state != ST_IDLE);
    assign underrun_out = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_ft_tx_arbiter.sv
//==============================================================================
// Module  : tb_ft_tx_arbiter
// Brief   : Scoreboard bench for ft_tx_arbiter with a two-channel FIFO model
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ft_tx_arbiter;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int PKT    = 16;
    localparam int SETTLE = 3;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic [NUM_CH-1:0]        ch_ready_in;
    logic [NUM_CH-1:0]        ch_empty_in;
    logic [NUM_CH-1:0]        ch_valid_in;
    logic [NUM_CH*DATA_W-1:0] ch_data_in;
    logic                     txe_n_in;
    logic [NUM_CH-1:0]        ch_rd_out;
    logic [DATA_W-1:0]        data_out;
    logic [DATA_W/8-1:0]      be_out;
    logic                     wr_n_out;
    logic [0:0]               grant_out;
    logic                     busy_out;
    logic                     underrun_out;

    ft_tx_arbiter #(
        .NUM_CH        (NUM_CH),
        .DATA_W        (DATA_W),
        .PACKET_SIZE   (PKT),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .ch_ready_in   (ch_ready_in),
        .ch_empty_in   (ch_empty_in),
        .ch_valid_in   (ch_valid_in),
        .ch_data_in    (ch_data_in),
        .txe_n_in      (txe_n_in),
        .ch_rd_out     (ch_rd_out),
        .data_out      (data_out),
        .be_out        (be_out),
        .wr_n_out      (wr_n_out),
        .grant_out     (grant_out),
        .busy_out      (busy_out),
        .underrun_out  (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    // Channel FIFO model: registered dout/valid, flags reflect contents after the edge
    logic [31:0] fq0[$];
    logic [31:0] fq1[$];
    logic [31:0] dout0 = '0, dout1 = '0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic        e0 = 1'b1, e1 = 1'b1;
    logic        r0 = 1'b0, r1 = 1'b0;
    logic [1:0]  force_rdy;

    always @(posedge clk_in) begin
        if (ch_rd_out[0] && fq0.size() > 0) begin
            dout0 <= fq0.pop_front();
            v0    <= 1'b1;
        end else begin
            v0    <= 1'b0;
        end
        if (ch_rd_out[1] && fq1.size() > 0) begin
            dout1 <= fq1.pop_front();
            v1    <= 1'b1;
        end else begin
            v1    <= 1'b0;
        end
        e0 <= (fq0.size() == 0);
        e1 <= (fq1.size() == 0);
        r0 <= (fq0.size() >= PKT) || force_rdy[0];
        r1 <= (fq1.size() >= PKT) || force_rdy[1];
    end

    assign ch_data_in  = {dout1, dout0};
    assign ch_valid_in = {v1, v0};
    assign ch_empty_in = {e1, e0};
    assign ch_ready_in = {r1, r0};

    typedef struct {
        int ch;
        int len;
    } burst_t;

    logic [31:0] exp_data[$];
    burst_t      exp_burst[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_underrun = 0;
    logic        sb_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int ch, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            if (ch == 0) fq0.push_back(base + 32'(k));
            else         fq1.push_back(base + 32'(k));
        end
    endtask

    task automatic expect_pkt(input int ch, input int len, input int nwords, input logic [31:0] base);
        burst_t b;
        b.ch  = ch;
        b.len = len;
        exp_burst.push_back(b);
        for (int k = 0; k < nwords; k++) exp_data.push_back(base + 32'(k));
    endtask

    // Counts cycles from the first cycle ready and txe_n qualify to the first read
    task automatic latency_check(input int ch);
        int k;
        k = 0;
        while (!ch_ready_in[ch] && k < 20) begin
            @(negedge clk_in);
            k++;
        end
        k = 0;
        while (ch_rd_out == '0 && k < 20) begin
            @(negedge clk_in);
            k++;
        end
        chk("arb_latency", 64'(k), 64'(1 + SETTLE));
    endtask

    task automatic wait_drain(input int max);
        int k;
        k = 0;
        while ((exp_data.size() != 0 || exp_burst.size() != 0 || busy_out) && k < max) begin
            @(negedge clk_in);
            k++;
        end
        chk("drain_in_time", 64'(k < max), 64'(1));
    endtask

    // Monitor: pops expected words on every bus write and expected bursts on every read run
    int   run    = 0;
    int   run_ch = 0;
    logic rd_h0  = 1'b0;
    logic rd_h1  = 1'b0;

    always @(negedge clk_in) begin
        burst_t b;
        if (underrun_out) n_underrun++;
        if (!sb_en) begin
            run = 0;
        end else begin
            if (!wr_n_out) begin
                chk("wr_two_after_rd", 64'(rd_h1), 64'(1));
                if (exp_data.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data %0h, expected no write", data_out);
                end else begin
                    chk("data", 64'(data_out), 64'(exp_data.pop_front()));
                end
            end
            if (ch_rd_out != '0) begin
                chk("rd_onehot", 64'($countones(ch_rd_out)), 64'(1));
                if (run == 0) run_ch = ch_rd_out[1] ? 1 : 0;
                run++;
            end else if (run > 0) begin
                if (exp_burst.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_burst: got ch %0d len %0d, expected none", run_ch, run);
                end else begin
                    b = exp_burst.pop_front();
                    chk("burst_ch", 64'(run_ch), 64'(b.ch));
                    chk("burst_len", 64'(run), 64'(b.len));
                end
                run = 0;
            end
        end
        rd_h1 = rd_h0;
        rd_h0 = (ch_rd_out != '0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int u0;
        int rd_seen;

        rst_in    = 1'b1;
        txe_n_in  = 1'b1;
        force_rdy = 2'b00;
        sb_en     = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_rd", 64'(ch_rd_out), 64'(0));
        chk("rst_data", 64'(data_out), 64'(0));
        chk("rst_wr_n", 64'(wr_n_out), 64'(1));
        chk("rst_grant", 64'(grant_out), 64'(0));
        chk("rst_busy", 64'(busy_out), 64'(0));
        chk("rst_underrun", 64'(underrun_out), 64'(0));
        chk("be_all_ones", 64'(be_out), 64'(4'hF));
        rst_in = 1'b0;
        sb_en  = 1'b1;
        @(negedge clk_in);

        // Single channel packet, ch0 wins first out of reset
        txe_n_in = 1'b0;
        fill(0, PKT, 32'h0000_0100);
        expect_pkt(0, PKT, PKT, 32'h0000_0100);
        latency_check(0);
        wait_drain(200);

        // Both ready: last grant was 0, so order is 1,0,1,0
        fill(0, 2*PKT, 32'h0000_1000);
        fill(1, 2*PKT, 32'h0001_1000);
        expect_pkt(1, PKT, PKT, 32'h0001_1000);
        expect_pkt(0, PKT, PKT, 32'h0000_1000);
        expect_pkt(1, PKT, PKT, 32'h0001_1010);
        expect_pkt(0, PKT, PKT, 32'h0000_1010);
        wait_drain(400);

        // Settle abort after two settle cycles, then a clean grant of the same channel
        txe_n_in = 1'b1;
        fill(0, PKT, 32'h0000_2000);
        expect_pkt(0, PKT, PKT, 32'h0000_2000);
        repeat (3) @(negedge clk_in);
        txe_n_in = 1'b0;
        @(negedge clk_in);
        chk("settle_entered", 64'(busy_out), 64'(1));
        @(negedge clk_in);
        @(negedge clk_in);
        txe_n_in = 1'b1;
        rd_seen = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (ch_rd_out != '0) rd_seen++;
        end
        chk("abort_no_read", 64'(rd_seen), 64'(0));
        chk("abort_idle", 64'(busy_out), 64'(0));
        txe_n_in = 1'b0;
        latency_check(0);
        wait_drain(200);

        // Underrun: 5 words behind a forced ready, empty stops the burst after 6 read cycles
        u0 = n_underrun;
        force_rdy[0] = 1'b1;
        fill(0, 5, 32'h0000_3000);
        expect_pkt(0, 6, 5, 32'h0000_3000);
        k = 0;
        while (!underrun_out && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        chk("underrun_seen", 64'(underrun_out), 64'(1));
        chk("underrun_rd_stopped", 64'(ch_rd_out), 64'(0));
        force_rdy[0] = 1'b0;
        k = 0;
        while (busy_out && k < 10) begin
            @(negedge clk_in);
            k++;
        end
        chk("underrun_busy_fall", 64'(k), 64'(2));
        wait_drain(100);
        chk("underrun_pulses", 64'(n_underrun - u0), 64'(1));

        fill(0, PKT, 32'h0000_4000);
        fill(1, PKT, 32'h0000_4100);
        expect_pkt(1, PKT, PKT, 32'h0000_4100);
        expect_pkt(0, PKT, PKT, 32'h0000_4000);
        wait_drain(300);

        // Reset during word 7 of a ch1 burst; last grant was 0, reset makes ch0 win first
        sb_en = 1'b0;
        fill(1, PKT, 32'h0000_5000);
        k = 0;
        while (ch_rd_out == '0 && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        repeat (7) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("midrst_rd", 64'(ch_rd_out), 64'(0));
        chk("midrst_wr_n", 64'(wr_n_out), 64'(1));
        chk("midrst_busy", 64'(busy_out), 64'(0));
        chk("midrst_grant", 64'(grant_out), 64'(0));
        rst_in = 1'b0;
        fq0.delete();
        fq1.delete();
        repeat (3) @(negedge clk_in);
        sb_en = 1'b1;
        fill(0, PKT, 32'h0000_6000);
        fill(1, PKT, 32'h0000_6100);
        expect_pkt(0, PKT, PKT, 32'h0000_6000);
        expect_pkt(1, PKT, PKT, 32'h0000_6100);
        wait_drain(300);

        // txe_n toggling during the burst must not shorten it
        fill(0, PKT, 32'h0000_7000);
        expect_pkt(0, PKT, PKT, 32'h0000_7000);
        latency_check(0);
        repeat (PKT) begin
            txe_n_in = ~txe_n_in;
            @(negedge clk_in);
        end
        txe_n_in = 1'b0;
        wait_drain(200);

        chk("exp_data_left", 64'(exp_data.size()), 64'(0));
        chk("exp_burst_left", 64'(exp_burst.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ft_tx_arbiter.md
# ft_tx_arbiter

- Single-clock scheduler that shares the FT-chip transmit bus (`txe_n`/`wr_n`/`be`/data) between `NUM_CH` packet FIFOs.
- It grants whole packets of `PACKET_SIZE` words, round-robin, to channels that hold at least one full packet.
- Each grant is guarded by a `txe_n` settle window. The block then generates the FIFO read strobes and registers the selected data onto the bus.
- It sits between the per-channel CDC FIFOs (read side, FT clock domain) and the FT bus pins.

## Interface

Parameters:
- `NUM_CH`, 2, number of requesting channels (2..8).
- `DATA_W`, 32, bus data width (multiple of 8).
- `PACKET_SIZE`, 1024, words per grant.
- `SETTLE_CYCLES`, 3, consecutive cycles `txe_n_in` must be low before reads start.

Ports:
- `clk_in` in 1: FT bus clock; sole clock.
- `rst_in` in 1: synchronous, active-high reset.
- `ch_ready_in` in `NUM_CH`: channel FIFO holds ≥ one packet (FIFO `!prog_empty`).
- `ch_empty_in` in `NUM_CH`: channel FIFO empty.
- `ch_valid_in` in `NUM_CH`: channel FIFO read-data valid, 1 cycle after read.
- `ch_data_in` in `NUM_CH*DATA_W`: channel FIFO dout; channel i occupies bits [i*DATA_W +: DATA_W].
- `txe_n_in` in 1: FT transmit FIFO has space (active low).
- `ch_rd_out` out `NUM_CH`: FIFO read enables, registered, at most one bit set.
- `data_out` out `DATA_W`: bus data, registered.
- `be_out` out `DATA_W/8`: byte enables, constant all ones.
- `wr_n_out` out 1: bus write strobe, active low, registered.
- `grant_out` out `$clog2(NUM_CH)`: channel currently or last granted.
- `busy_out` out 1: high in any state other than IDLE.
- `underrun_out` out 1: one-cycle pulse when a burst is aborted on empty.

## Operation

State machine IDLE → SETTLE → BURST → DRAIN → IDLE.

- **IDLE**
  - All `ch_rd_out` are 0.
  - If `txe_n_in`=0 and any `ch_ready_in` bit is set, pick a channel round-robin. The search starts at `last_grant+1` modulo `NUM_CH`; the first ready channel wins.
  - On a pick, latch `grant`, clear `settle_ctr`, go to SETTLE.
- **SETTLE**
  - Each cycle with `txe_n_in`=0 and `ch_ready_in[grant]`=1 increments `settle_ctr`.
  - If either condition is 0, return to IDLE. `last_grant` is unchanged and the same channel may be re-picked.
  - When `settle_ctr` = `SETTLE_CYCLES-1` with both conditions true, go to BURST and clear `word_ctr`.
- **BURST**
  - `ch_rd_out[grant]`=1 on every BURST cycle; `word_ctr` increments per cycle.
  - `txe_n_in` is not re-sampled: the packet fits the FT buffer.
  - When `word_ctr` = `PACKET_SIZE-1`, this is the last read; go to DRAIN.
  - If `ch_empty_in[grant]`=1 in BURST, pulse `underrun_out`, deassert reads from the next cycle, and go to DRAIN.
- **DRAIN**
  - Hold for 2 cycles with reads low, covering FIFO read latency plus the output register.
  - Then set `last_grant` = `grant` and return to IDLE.
- **Datapath**
  - Every cycle: `data_out` ← `ch_data_in[grant]`, `wr_n_out` ← `!(ch_valid_in[grant] && state≠IDLE)`.
  - Valids arriving in DRAIN are forwarded; valids arriving in IDLE are dropped.
- **Width rules**
  - `settle_ctr` width is `$clog2(SETTLE_CYCLES+1)`.
  - `word_ctr` width is `$clog2(PACKET_SIZE+1)`.
  - No counter wraps: both are cleared on state entry.

## Timing

- **Reset values** (all outputs registered, all take effect on the edge where `rst_in`=1):
  - state IDLE, `ch_rd_out`=0, `data_out`=0, `wr_n_out`=1.
  - `grant_out`=0, `busy_out`=0, `underrun_out`=0.
  - `last_grant`=`NUM_CH-1`, so channel 0 wins first.
- **Reset mid-burst**: reads stop on the next edge and the packet is abandoned. FIFO reset is the integrator's responsibility.
- **Arbitration latency**: `ch_ready_in`/`txe_n_in` qualify at edge t0. The first `ch_rd_out` high is at t0+1+`SETTLE_CYCLES`.
- **Read to bus**: `ch_rd_out` high at cycle t gives FIFO valid at t+1 and `wr_n_out`=0 at t+2.
- **Packet length**: exactly `PACKET_SIZE` consecutive `ch_rd_out` cycles per normal grant, giving `PACKET_SIZE` consecutive `wr_n_out`=0 cycles.
- **Back-to-back**: minimum gap between bursts is 2 (DRAIN) + 1 (IDLE) + `SETTLE_CYCLES`.
- **Simultaneous requests**: round-robin order only. `ch_ready_in` changes of non-granted channels have no effect until IDLE.

## Structure

- **Shared package `ft_tx_pkg`**:
  - state enum (IDLE/SETTLE/BURST/DRAIN);
  - defaults `PACKET_SIZE`=1024 and `SETTLE_CYCLES`=3, shared with the channel FIFO wrappers so that the prog_empty threshold equals `PACKET_SIZE`.
- **Sub-module `rr_picker`**: combinational. Inputs are the request vector and `last_grant`; outputs are `found` and `index`. Parameterised by `NUM_CH`.

## Test plan

- **Single channel**: ch0 ready, `txe_n_in`=0, `PACKET_SIZE`=16 → `ch_rd_out`=01 for 16 cycles starting 4 cycles after the request edge. 16 `wr_n_out` lows 2 cycles later; `data_out` matches the FIFO order.
- **Round robin**: ch0 and ch1 both ready continuously → grants alternate 0,1,0,1, each burst 16 words, no interleaved words.
- **Settle abort**: `txe_n_in` rises after 2 settle cycles → no read. Back to IDLE; the same channel is granted once `txe_n_in` is low for 3 consecutive cycles.
- **Underrun**: empty asserted after 5 reads → `underrun_out` pulses once, reads stop next cycle, `busy_out` falls 2 cycles later. The next grant goes to the other channel.
- **Reset mid-burst**: `rst_in` high during word 7 → next edge gives `ch_rd_out`=0, `wr_n_out`=1, `busy_out`=0; after release ch0 wins first.
- **txe_n ignored in BURST**: `txe_n_in` toggles during the burst → all 16 reads still issued.
